// File: rtl/uart_cmd_dispatcher.sv
// Oversampled 8N1 UART receiver feeding a fixed-length packet dispatcher.
// The opcode byte selects which command bus carries the payload bytes.
module uart_cmd_dispatcher #(
    parameter int PKT_LEN    = 13,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dcom,
    input  logic       tick_in,
    output logic [7:0] bus_create,
    output logic [7:0] bus_issue,
    output logic [7:0] bus_transfer,
    output logic [7:0] bus_refer,
    output logic       vld_create,
    output logic       vld_issue,
    output logic       vld_transfer,
    output logic       vld_refer,
    output logic [3:0] cmd_sel,
    output logic       pkt_done,
    output logic       bad_opcode,
    output logic       frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(PKT_LEN);

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(PKT_LEN - 2);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] D_IDLE    = 2'd0;
    localparam logic [1:0] D_PAYLOAD = 2'd1;
    localparam logic [1:0] D_DONE    = 2'd2;

    logic          dcom_q1;
    logic          dcom_s;
    logic [1:0]    rx_state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_byte;
    logic          rx_valid;

    logic [1:0]    d_state;
    logic [CW-1:0] pay_cnt;
    logic [7:0]    data_q;
    logic          vld_q;

    // Synchroniser resets to the idle-high line level to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcom_q1 <= 1'b1;
            dcom_s  <= 1'b1;
        end else begin
            dcom_q1 <= dcom;
            dcom_s  <= dcom_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tick_in) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!dcom_s) begin
                            rx_state <= RX_START;
                            tick_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (tick_cnt == T_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            rx_state <= dcom_s ? RX_IDLE : RX_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            rx_byte  <= {dcom_s, rx_byte[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                rx_state <= RX_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt  <= '0;
                            rx_valid  <= dcom_s;
                            frame_err <= !dcom_s;
                            rx_state  <= RX_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state    <= D_IDLE;
            pay_cnt    <= '0;
            data_q     <= '0;
            cmd_sel    <= '0;
            vld_q      <= 1'b0;
            pkt_done   <= 1'b0;
            bad_opcode <= 1'b0;
        end else begin
            vld_q      <= 1'b0;
            pkt_done   <= 1'b0;
            bad_opcode <= 1'b0;
            case (d_state)
                D_IDLE: begin
                    if (rx_valid) begin
                        if (rx_byte <= 8'd3) begin
                            cmd_sel <= 4'(4'b0001 << rx_byte[1:0]);
                            pay_cnt <= '0;
                            d_state <= D_PAYLOAD;
                        end else begin
                            bad_opcode <= 1'b1;
                        end
                    end
                end
                D_PAYLOAD: begin
                    if (rx_valid) begin
                        data_q  <= rx_byte;
                        vld_q   <= 1'b1;
                        pay_cnt <= pay_cnt + CW'(1);
                        if (pay_cnt == C_LAST) begin
                            pkt_done <= 1'b1;
                            d_state  <= D_DONE;
                        end
                    end
                end
                D_DONE: begin
                    cmd_sel <= '0;
                    data_q  <= '0;
                    pay_cnt <= '0;
                    d_state <= D_IDLE;
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    // Gating by cmd_sel keeps every non-selected bus and strobe at zero.
    assign bus_create   = data_q & {8{cmd_sel[0]}};
    assign bus_issue    = data_q & {8{cmd_sel[1]}};
    assign bus_transfer = data_q & {8{cmd_sel[2]}};
    assign bus_refer    = data_q & {8{cmd_sel[3]}};

    assign vld_create   = vld_q & cmd_sel[0];
    assign vld_issue    = vld_q & cmd_sel[1];
    assign vld_transfer = vld_q & cmd_sel[2];
    assign vld_refer    = vld_q & cmd_sel[3];

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Randomised serial stimulus for uart_cmd_dispatcher, scored against a
// packet-level model of the command protocol.
module tb_uart_cmd_dispatcher;

    localparam int PKT_LEN = 13;
    localparam int PAY     = PKT_LEN - 1;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
        logic       done;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       dcom;
    logic       tick_in;
    logic [7:0] bus_create;
    logic [7:0] bus_issue;
    logic [7:0] bus_transfer;
    logic [7:0] bus_refer;
    logic       vld_create;
    logic       vld_issue;
    logic       vld_transfer;
    logic       vld_refer;
    logic [3:0] cmd_sel;
    logic       pkt_done;
    logic       bad_opcode;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  got_bad  = 0;
    int  got_ferr = 0;
    int  exp_bad  = 0;
    int  exp_ferr = 0;
    bit  prev_done = 0;

    bit       m_in_pkt = 0;
    int       m_sel    = 0;
    int       m_pos    = 0;

    uart_cmd_dispatcher #(.PKT_LEN(PKT_LEN), .OVERSAMPLE(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dcom         (dcom),
        .tick_in      (tick_in),
        .bus_create   (bus_create),
        .bus_issue    (bus_issue),
        .bus_transfer (bus_transfer),
        .bus_refer    (bus_refer),
        .vld_create   (vld_create),
        .vld_issue    (vld_issue),
        .vld_transfer (vld_transfer),
        .vld_refer    (vld_refer),
        .cmd_sel      (cmd_sel),
        .pkt_done     (pkt_done),
        .bad_opcode   (bad_opcode),
        .frame_err    (frame_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial tick_in = 0;
    always @(negedge clk) tick_in = ~tick_in;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle-level observer: protocol invariants plus an event log.
    always @(negedge clk) begin
        ev_t ev;
        check("sel_onehot0", 64'($onehot0(cmd_sel)), 64'd1);
        check("vld_onehot0",
              64'($onehot0({vld_create, vld_issue, vld_transfer, vld_refer})),
              64'd1);
        check("unsel_bus_zero",
              {32'd0,
               bus_create   & ~{8{cmd_sel[0]}},
               bus_issue    & ~{8{cmd_sel[1]}},
               bus_transfer & ~{8{cmd_sel[2]}},
               bus_refer    & ~{8{cmd_sel[3]}}}, 64'd0);
        if (prev_done)
            check("clear_after_done",
                  {28'd0, cmd_sel, bus_create, bus_issue,
                   bus_transfer, bus_refer}, 64'd0);
        prev_done = pkt_done;
        if (vld_create || vld_issue || vld_transfer || vld_refer || pkt_done) begin
            ev.done = pkt_done;
            if (vld_create) begin
                ev.ch = 3'd0; ev.data = bus_create;
            end else if (vld_issue) begin
                ev.ch = 3'd1; ev.data = bus_issue;
            end else if (vld_transfer) begin
                ev.ch = 3'd2; ev.data = bus_transfer;
            end else if (vld_refer) begin
                ev.ch = 3'd3; ev.data = bus_refer;
            end else begin
                ev.ch = 3'd4; ev.data = 8'd0;
            end
            got_q.push_back(ev);
        end
        if (bad_opcode) got_bad++;
        if (frame_err)  got_ferr++;
    end

    // Packet-level reference: opcode then PAY bytes to the chosen bus.
    task automatic model_byte(input logic [7:0] b);
        ev_t ev;
        if (!m_in_pkt) begin
            if (b <= 8'd3) begin
                m_in_pkt = 1;
                m_sel    = int'(b);
                m_pos    = 0;
            end else begin
                exp_bad++;
            end
        end else begin
            ev.ch   = 3'(m_sel);
            ev.data = b;
            ev.done = (m_pos == PAY - 1);
            exp_q.push_back(ev);
            m_pos++;
            if (m_pos == PAY) m_in_pkt = 0;
        end
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick_in) k++;
        end
    endtask

    task automatic drive(input logic b, input int n);
        @(negedge clk);
        dcom = b;
        wait_ticks(n);
    endtask

    task automatic send_raw(input logic [7:0] b, input bit stop_ok);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(b[i], 16);
        if (stop_ok) begin
            drive(1'b1, 16);
        end else begin
            drive(1'b0, 12);
            drive(1'b1, 16);
        end
        drive(1'b1, 4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b1);
        model_byte(b);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
    endtask

    task automatic compare_events(input string tag);
        ev_t g;
        ev_t e;
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, 64'd0, 64'(e));
            end else begin
                g = got_q.pop_front();
                check({tag, "_event"}, 64'(g), 64'(e));
            end
        end
        check({tag, "_extra"}, 64'(got_q.size()), 64'd0);
        got_q.delete();
        check({tag, "_bad_opcode"}, 64'(got_bad), 64'(exp_bad));
        check({tag, "_frame_err"}, 64'(got_ferr), 64'(exp_ferr));
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {12'd0, cmd_sel, bus_create, bus_issue, bus_transfer,
                    bus_refer, vld_create, vld_issue, vld_transfer,
                    vld_refer, pkt_done, bad_opcode, frame_err, 1'b0},
              64'd0);
    endtask

    initial begin
        int op;
        dcom  = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_quiet("reset_state");
        rst_n = 1'b1;
        drive(1'b1, 8);

        // Reset in the middle of a packet and of a byte.
        send_byte(8'h02);
        send_byte(8'h11);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 10);
        compare_events("pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        dcom  = 1'b1;
        m_in_pkt = 0;
        repeat (3) @(negedge clk);
        check_quiet("mid_reset");
        rst_n = 1'b1;
        drive(1'b1, 20);
        check_quiet("post_reset");
        send_byte(8'h00);
        check("create_sel", 64'(cmd_sel), 64'h1);
        send_rand(PAY);
        compare_events("create");

        send_byte(8'h01);
        check("issue_sel", 64'(cmd_sel), 64'h2);
        send_byte(8'hA5);
        check("issue_first", 64'(bus_issue), 64'hA5);
        send_byte(8'h3C);
        send_rand(PAY - 2);
        check("issue_sel_clear", 64'(cmd_sel), 64'h0);
        compare_events("issue");

        send_byte(8'h02);
        send_rand(PAY);
        send_byte(8'h03);
        send_rand(PAY);
        compare_events("xfer_refer");

        send_byte(8'h07);
        check("bad_sel_idle", 64'(cmd_sel), 64'h0);
        send_byte(8'h00);
        check("after_bad_sel", 64'(cmd_sel), 64'h1);
        send_rand(5);
        send_raw(8'h55, 1'b0);
        exp_ferr++;
        drive(1'b1, 16);
        check("ferr_sel_kept", 64'(cmd_sel), 64'h1);
        send_rand(PAY - 5);
        compare_events("bad_and_ferr");

        send_byte(8'h03);
        drive(1'b0, 3);
        drive(1'b1, 20);
        check("glitch_quiet", 64'(bus_refer), 64'h0);
        send_byte(8'h81);
        check("glitch_then_81", 64'(bus_refer), 64'h81);
        send_rand(PAY - 1);
        compare_events("glitch");

        for (int p = 0; p < 4; p++) begin
            op = int'($urandom_range(0, 7));
            send_byte(8'(op));
            if (op <= 3) send_rand(PAY);
        end
        compare_events("random");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Serial command front end for the key-value ledger.
- Oversampled 8N1 UART receiver on `dcom` assembles bytes. A fixed-length packet FSM decodes the first byte of each packet as an opcode: 0 = create, 1 = issue, 2 = transfer, 3 = refer.
- Each remaining payload byte is steered onto the selected command's 8-bit output bus. All non-selected buses are forced to zero.

Parameters:
- PKT_LEN, 13, total bytes per packet including the opcode byte (payload = PKT_LEN-1).
- OVERSAMPLE, 16, `tick_in` pulses per bit period.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dcom  in  1  UART serial input, idle high, LSB first.
- tick_in  in  1  one-clk baud strobe at OVERSAMPLE x baud rate.
- bus_create  out  8  payload byte for create (0 when not selected).
- bus_issue  out  8  payload byte for issue (0 when not selected).
- bus_transfer  out  8  payload byte for transfer (0 when not selected).
- bus_refer  out  8  payload byte for refer (0 when not selected).
- vld_create, vld_issue, vld_transfer, vld_refer  out  1 each  one-clk strobe, new byte on the matching bus.
- cmd_sel  out  4  one-hot active command: bit0 create, bit1 issue, bit2 transfer, bit3 refer.
- pkt_done  out  1  one-clk pulse after the last payload byte.
- bad_opcode  out  1  one-clk pulse, opcode byte greater than 3.
- frame_err  out  1  one-clk pulse, stop bit sampled low.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; receiver returns to RX_IDLE; dispatcher returns to D_IDLE; byte counter cleared.
- Reset mid-byte or mid-packet aborts immediately; partial data is discarded.
- Synchronise `dcom` with a 2-flop synchroniser before use.
- Receiver state and counters advance only on clk edges where `tick_in`=1.
- Receiver FSM:
  - RX_IDLE: synchronised `dcom`=0 -> RX_START, tick count 0.
  - RX_START: at tick count OVERSAMPLE/2-1 (7), re-sample. Low -> RX_DATA with counters cleared. High -> glitch, back to RX_IDLE, no output.
  - RX_DATA: every OVERSAMPLE ticks (mid-bit), shift the sample into bit[n], LSB first. After bit 7 -> RX_STOP.
  - RX_STOP: after OVERSAMPLE ticks, sample the stop bit, then return to RX_IDLE.
    - Stop bit high -> byte valid.
    - Stop bit low -> frame_err pulse; byte discarded.
- Internal rx_valid is asserted the clk after the stop-bit sample tick.
- Dispatcher FSM, outputs registered, one clk after rx_valid:
  - D_IDLE, byte 0-3: set cmd_sel one-hot, payload counter = 0, go to D_PAYLOAD. The opcode byte itself is not forwarded to any bus.
  - D_IDLE, byte >3: bad_opcode pulse; stay in D_IDLE. The next byte is again treated as an opcode.
  - D_PAYLOAD, each rx_valid: the selected bus takes the byte and its vld_* pulses; counter increments.
  - The selected bus holds its value until the next byte, reset, or packet end.
  - When counter reaches PKT_LEN-1: pkt_done pulses in the same cycle as the last vld_*.
  - The following clk: cmd_sel is cleared, all buses go to 0, FSM returns to D_IDLE.
- Non-selected buses are always 0 (AND-gating with cmd_sel).
- frame_err during D_PAYLOAD does not advance the counter; the packet continues.
- No timeout: a partial packet waits indefinitely.
- At most one vld_* asserted in any cycle; cmd_sel is always zero-hot or one-hot.

Test Plan:
- Reset with rst_n=0 mid-stream -> all buses 0, cmd_sel=0000, no strobes. Release, then send opcode 0x00 -> cmd_sel=0001.
- Send 0x01 followed by payload 0xA5, 0x3C, ..., 12 bytes total -> each byte appears on bus_issue with vld_issue. Other buses stay 0. pkt_done coincides with the 12th strobe. cmd_sel=0000 one clk later.
- Send 0x02 packet, then 0x03 packet back-to-back -> bus_transfer receives the first payload, bus_refer the second. No cross-leakage. Each packet gives exactly 12 strobes.
- Send opcode 0x07 -> bad_opcode pulse, state stays D_IDLE. Then send 0x00 -> cmd_sel=0001.
- Send byte 0x55 with stop bit forced low -> frame_err pulse, no vld_*, counter unchanged.
- Drive a start-bit glitch of 3 ticks low -> no byte, no error. A subsequent valid byte 0x81 is received correctly (LSB first).
